issue_scheduler: RTL and testbench

- ID→EX issue controller for the pipelined MIPS core.
- Takes the 39-bit packed decode word from the ID-stage packer and decides, each cycle, whether to issue it, insert a bubble or flush it.
- Owns the ID/EX control register and tracks EX/MEM destinations for load-use stalls and operand-forwarding selects.

---
 rtl/issue_scheduler.sv | 128 ++++++++++++
 tb/tb_issue_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scheduler.sv
// ID->EX issue controller: issues, bubbles or flushes the decode word, handles load-use stalls and forwarding selects.
// Optional stall counter output perf_stalls is built when ISSUE_STALL_CNT_EN is defined.
module issue_scheduler #(
    parameter int         CTRL_W   = 39,
    parameter logic [1:0] LOAD_SEL = 2'b01
`ifdef ISSUE_STALL_CNT_EN
    ,
    parameter int         CNT_W    = 32
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    output logic              id_ready,
    input  logic              ex_ready,
    input  logic              ex_redirect,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel
`ifdef ISSUE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  perf_stalls
`endif
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    logic              ex_valid_q, ex_valid_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic [4:0]        mem_cad_q, mem_cad_d;
    logic              mem_we_q, mem_we_d;
    logic [1:0]        fwd_a_q, fwd_a_d;
    logic [1:0]        fwd_b_q, fwd_b_d;

    logic [4:0] id_rs, id_rt, ex_cad;
    logic       uses_rt, ex_we, ex_load, hazard, issue;

    assign id_rs   = id_ctrl[9:5];
    assign id_rt   = id_ctrl[4:0];
    assign uses_rt = ~id_ctrl[34] | id_ctrl[15];
    assign ex_cad  = ex_ctrl_q[29:25];
    assign ex_we   = ex_ctrl_q[24];
    assign ex_load = ex_valid_q & ex_we & (ex_ctrl_q[23:22] == LOAD_SEL);

    assign hazard = id_valid & ex_load & (ex_cad != 5'd0) &
                    ((ex_cad == id_rs) | (uses_rt & (ex_cad == id_rt)));

    // A redirect flushes the ID word, so it is consumed even under a hazard.
    assign id_ready = ex_ready & (~hazard | ex_redirect);
    assign issue    = id_valid & ~hazard & ~ex_redirect;

    function automatic logic [1:0] src_sel(input logic [4:0] r);
        logic [1:0] s;
        s = SEL_RF;
        if (r != 5'd0) begin
            if (ex_valid_q & ex_we & (ex_cad == r))
                s = SEL_EX;
            else if (mem_we_q & (mem_cad_q == r))
                s = SEL_MEM;
        end
        return s;
    endfunction

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_ctrl_d  = ex_ctrl_q;
        mem_cad_d  = mem_cad_q;
        mem_we_d   = mem_we_q;
        fwd_a_d    = fwd_a_q;
        fwd_b_d    = fwd_b_q;
        if (ex_ready) begin
            ex_valid_d = issue;
            ex_ctrl_d  = issue ? id_ctrl : '0;
            mem_cad_d  = ex_valid_q ? ex_cad : 5'd0;
            mem_we_d   = ex_valid_q & ex_we;
            fwd_a_d    = issue ? src_sel(id_rs) : SEL_RF;
            fwd_b_d    = (issue & uses_rt) ? src_sel(id_rt) : SEL_RF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
            mem_cad_q  <= 5'd0;
            mem_we_q   <= 1'b0;
            fwd_a_q    <= SEL_RF;
            fwd_b_q    <= SEL_RF;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_ctrl_q  <= ex_ctrl_d;
            mem_cad_q  <= mem_cad_d;
            mem_we_q   <= mem_we_d;
            fwd_a_q    <= fwd_a_d;
            fwd_b_q    <= fwd_b_d;
        end
    end

    assign ex_valid  = ex_valid_q;
    assign ex_ctrl   = ex_ctrl_q;
    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;

`ifdef ISSUE_STALL_CNT_EN
    logic [CNT_W-1:0] stalls_q, stalls_d;
    logic             stall_evt;

    assign stall_evt = id_valid & ex_ready & hazard & ~ex_redirect;

    always_comb begin
        stalls_d = stalls_q;
        if (stall_evt && (stalls_q != {CNT_W{1'b1}}))
            stalls_d = stalls_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stalls_q <= '0;
        else        stalls_q <= stalls_d;
    end

    assign perf_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_issue_scheduler.sv
// Self-checking bench for issue_scheduler: directed pipeline scenarios followed by randomized traffic,
// all compared against a behavioural model of the ID/EX/MEM slots.
module tb_issue_scheduler;

  localparam int W = 39;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         id_valid;
  logic [W-1:0] id_ctrl;
  logic         id_ready;
  logic         ex_ready;
  logic         ex_redirect;
  logic         ex_valid;
  logic [W-1:0] ex_ctrl;
  logic [1:0]   fwd_a_sel;
  logic [1:0]   fwd_b_sel;
`ifdef ISSUE_STALL_CNT_EN
  logic [31:0]  perf_stalls;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  issue_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_ctrl    (id_ctrl),
    .id_ready   (id_ready),
    .ex_ready   (ex_ready),
    .ex_redirect(ex_redirect),
    .ex_valid   (ex_valid),
    .ex_ctrl    (ex_ctrl),
    .fwd_a_sel  (fwd_a_sel),
    .fwd_b_sel  (fwd_b_sel)
`ifdef ISSUE_STALL_CNT_EN
    ,
    .perf_stalls(perf_stalls)
`endif
  );

  // ---------------- reference model ----------------
  // The model tracks the instruction sitting in EX and the destination that moved on to MEM.
  logic         m_ex_valid;
  logic [W-1:0] m_ex_word;
  int           m_mem_dest;    // -1 when nothing writing in MEM
  logic [1:0]   m_fa, m_fb;
  longint       m_stalls;

  function automatic int f_cad(input logic [W-1:0] w); return int'(w[29:25]); endfunction
  function automatic int f_rs (input logic [W-1:0] w); return int'(w[9:5]);   endfunction
  function automatic int f_rt (input logic [W-1:0] w); return int'(w[4:0]);   endfunction
  function automatic bit f_writes(input logic [W-1:0] w); return w[24]; endfunction
  function automatic bit f_is_load(input logic [W-1:0] w); return w[24] && (w[23:22] == 2'b01); endfunction
  function automatic bit f_reads_rt(input logic [W-1:0] w); return (w[34] == 1'b0) || w[15]; endfunction

  function automatic logic [W-1:0] make_word(input int cad, input bit we, input int gmux, input bit imm,
                                             input bit st, input int rs, input int rt, input int rd);
    logic [W-1:0] w;
    w = '0;
    w[34]    = imm;
    w[29:25] = cad[4:0];
    w[24]    = we;
    w[23:22] = gmux[1:0];
    w[15]    = st;
    w[14:10] = rd[4:0];
    w[9:5]   = rs[4:0];
    w[4:0]   = rt[4:0];
    return w;
  endfunction

  task automatic model_reset();
    m_ex_valid = 1'b0;
    m_ex_word  = '0;
    m_mem_dest = -1;
    m_fa       = 2'b00;
    m_fb       = 2'b00;
    m_stalls   = 0;
  endtask

  // Nearest live producer of register r: 1 = instruction in EX, 2 = instruction in MEM, 0 = regfile.
  function automatic logic [1:0] model_src(input int r);
    if (r == 0) return 2'b00;
    if (m_ex_valid && f_writes(m_ex_word) && f_cad(m_ex_word) == r) return 2'b01;
    if (m_mem_dest == r) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit model_hazard(input bit v, input logic [W-1:0] w);
    int d;
    if (!v || !m_ex_valid || !f_is_load(m_ex_word)) return 1'b0;
    d = f_cad(m_ex_word);
    if (d == 0) return 1'b0;
    return (d == f_rs(w)) || (f_reads_rt(w) && d == f_rt(w));
  endfunction

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("ex_valid", ex_valid, m_ex_valid);
    check_eq("ex_ctrl", ex_ctrl, m_ex_word);
    check_eq("fwd_a_sel", fwd_a_sel, m_fa);
    check_eq("fwd_b_sel", fwd_b_sel, m_fb);
`ifdef ISSUE_STALL_CNT_EN
    check_eq("perf_stalls", perf_stalls, m_stalls);
`endif
  endtask

  // ---------------- driver ----------------
  // Called at a negedge; drives one cycle, checks id_ready, advances the model at posedge, checks outputs.
  task automatic step(input bit v, input logic [W-1:0] w, input bit rdy, input bit redir, output bit consumed);
    bit hz, iss;
    logic [1:0] na, nb;
    int nmem;
    id_valid    = v;
    id_ctrl     = w;
    ex_ready    = rdy;
    ex_redirect = redir;
    #1;
    hz = model_hazard(v, w);
    consumed = rdy && (!hz || redir);
    check_eq("id_ready", id_ready, consumed);
    @(posedge clk);
    if (rdy) begin
      iss  = v && !hz && !redir;
      nmem = (m_ex_valid && f_writes(m_ex_word)) ? f_cad(m_ex_word) : -1;
      na   = iss ? model_src(f_rs(w)) : 2'b00;
      nb   = (iss && f_reads_rt(w)) ? model_src(f_rt(w)) : 2'b00;
      if (v && hz && !redir && m_stalls != 64'hFFFF_FFFF) m_stalls++;
      m_ex_valid = iss;
      m_ex_word  = iss ? w : '0;
      m_mem_dest = nmem;
      m_fa       = na;
      m_fb       = nb;
    end
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit c;
    logic [W-1:0] pend;
    bit have;
    logic [63:0] r64;

    rst_n = 1'b0; id_valid = 1'b0; id_ctrl = '0; ex_ready = 1'b0; ex_redirect = 1'b0;
    model_reset();
    #3;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Independent stream: add r3,r1,r2 then sub r6,r4,r5.
    step(1, make_word(3, 1, 0, 0, 0, 1, 2, 3), 1, 0, c);
    step(1, make_word(6, 1, 0, 0, 0, 4, 5, 6), 1, 0, c);
    check_eq("indep_fwd", {fwd_a_sel, fwd_b_sel}, 4'b0000);

    // ALU->ALU: EX forward then MEM forward.
    step(1, make_word(3, 1, 0, 0, 0, 1, 2, 3), 1, 0, c);
    step(1, make_word(7, 1, 0, 0, 0, 3, 2, 7), 1, 0, c);
    check_eq("alu_ex_fwd", fwd_a_sel, 2'b01);
    step(1, make_word(9, 1, 0, 0, 0, 3, 1, 9), 1, 0, c);
    check_eq("alu_mem_fwd", fwd_a_sel, 2'b10);

    // Load-use: one bubble then MEM forward.
    step(1, make_word(8, 1, 1, 1, 0, 2, 8, 0), 1, 0, c);
    step(1, make_word(10, 1, 0, 0, 0, 8, 1, 10), 1, 0, c);
    check_eq("lu_bubble", {ex_valid, ex_ctrl}, 40'd0);
    step(1, make_word(10, 1, 0, 0, 0, 8, 1, 10), 1, 0, c);
    check_eq("lu_fwd", fwd_a_sel, 2'b10);

    // Load to r0 never stalls or forwards.
    step(1, make_word(0, 1, 1, 1, 0, 2, 0, 0), 1, 0, c);
    step(1, make_word(11, 1, 0, 0, 0, 0, 1, 11), 1, 0, c);
    check_eq("r0_fwd", fwd_a_sel, 2'b00);

    // Redirect while a load-use hazard is present.
    step(1, make_word(9, 1, 1, 1, 0, 2, 9, 0), 1, 0, c);
    step(1, make_word(12, 1, 0, 0, 0, 9, 1, 12), 1, 1, c);
    check_eq("redir_flush", ex_valid, 1'b0);

    // Back-to-back loads to the same register.
    step(1, make_word(5, 1, 1, 1, 0, 1, 5, 0), 1, 0, c);
    step(1, make_word(5, 1, 1, 1, 0, 5, 5, 0), 1, 0, c);
    step(1, make_word(5, 1, 1, 1, 0, 5, 5, 0), 1, 0, c);
    step(1, make_word(13, 1, 0, 0, 0, 5, 2, 13), 1, 0, c);
    step(1, make_word(13, 1, 0, 0, 0, 5, 2, 13), 1, 0, c);

    // EX hold for three cycles, then asynchronous reset mid-hold.
    step(1, make_word(14, 1, 0, 0, 0, 1, 2, 14), 1, 0, c);
    for (int k = 0; k < 3; k++) step(1, make_word(15, 1, 0, 0, 0, 14, 1, 15), 0, 0, c);
    check_eq("hold_ctrl", ex_ctrl, make_word(14, 1, 0, 0, 0, 1, 2, 14));
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("async_rst_valid", ex_valid, 1'b0);
    check_eq("async_rst_ctrl", ex_ctrl, '0);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic; ID keeps presenting a word until it is consumed.
    have = 0;
    pend = '0;
    for (int n = 0; n < 400; n++) begin
      bit v, rdy, redir;
      if (!have) begin
        r64 = {$urandom, $urandom};
        pend = r64[W-1:0];
        pend[29:25] = 5'($urandom_range(0, 4));
        pend[9:5]   = 5'($urandom_range(0, 4));
        pend[4:0]   = 5'($urandom_range(0, 4));
        have = 1;
      end
      v     = ($urandom_range(0, 3) != 0);
      rdy   = ($urandom_range(0, 4) != 0);
      redir = rdy && ($urandom_range(0, 9) == 0);
      step(v, pend, rdy, redir, c);
      if (v && c) have = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
